// File: rtl/iterative_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iterative_divider_pkg
// Purpose  : Shared types and defaults for the iterative restoring divider
//            (state encoding, default widths, divide-by-zero quotient).
// Revision : 1.0 - initial release
// ============================================================================
package iterative_divider_pkg;

  localparam int DIV_DATA_WIDTH = 32;
  localparam int DIV_CNT_WIDTH  = 5;

  // Quotient reported when the divisor is zero (all ones at the default width)
  localparam logic [DIV_DATA_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    ZERO = 2'd3
  } div_state_t;

endpackage : iterative_divider_pkg
`default_nettype wire

// File: rtl/iterative_divider_if.sv
`default_nettype none
// ============================================================================
// Module   : iterative_divider_if
// Purpose  : Request/result bundle between the EX-stage controller (master)
//            and the iterative divider (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface iterative_divider_if
  import iterative_divider_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_DATA_WIDTH
);

  logic                  start;
  logic                  signed_div;
  logic                  cancel;
  logic [DATA_WIDTH-1:0] operand_1;
  logic [DATA_WIDTH-1:0] operand_2;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] result_lo;
  logic [DATA_WIDTH-1:0] result_hi;
  logic                  div_by_zero;

  modport master (
    output start, signed_div, cancel, operand_1, operand_2,
    input  busy, done, result_lo, result_hi, div_by_zero
  );

  modport slave (
    input  start, signed_div, cancel, operand_1, operand_2,
    output busy, done, result_lo, result_hi, div_by_zero
  );

endinterface : iterative_divider_if
`default_nettype wire

// File: rtl/iterative_divider_div_step.sv
`default_nettype none
// ============================================================================
// Module   : iterative_divider_div_step
// Purpose  : One radix-2 restoring iteration: shift {rem, quo} left, try to
//            subtract the divisor, keep the difference if it is non-negative.
// Revision : 1.0 - initial release
// ============================================================================
module iterative_divider_div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_rem,
  input  logic [DATA_WIDTH-1:0] i_quo,
  input  logic [DATA_WIDTH-1:0] i_divisor,
  output logic [DATA_WIDTH-1:0] o_rem,
  output logic [DATA_WIDTH-1:0] o_quo
);

  // rem < divisor always holds on entry, so the shifted remainder is below
  // 2*divisor and the trial difference lies in (-2^W, 2^W): W+1 bits are
  // enough and the top bit is a true sign.
  logic [DATA_WIDTH:0] w_shifted;
  logic [DATA_WIDTH:0] w_trial;

  // Trial subtraction and restore decision
  always_comb begin
    w_shifted = {i_rem, i_quo[DATA_WIDTH-1]};
    w_trial   = w_shifted - {1'b0, i_divisor};
    if (!w_trial[DATA_WIDTH]) begin
      o_rem = w_trial[DATA_WIDTH-1:0];
      o_quo = {i_quo[DATA_WIDTH-2:0], 1'b1};
    end else begin
      o_rem = w_shifted[DATA_WIDTH-1:0];
      o_quo = {i_quo[DATA_WIDTH-2:0], 1'b0};
    end
  end

endmodule : iterative_divider_div_step
`default_nettype wire

// File: rtl/iterative_divider.sv
`default_nettype none
// ============================================================================
// Module   : iterative_divider
// Purpose  : Multi-cycle DIV/DIVU unit for the EX stage. Quotient on
//            result_lo, remainder on result_hi. Magnitudes are divided with a
//            restoring loop and signs are applied in a final fix-up cycle.
// Revision : 1.0 - initial release
// ============================================================================
module iterative_divider
  import iterative_divider_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_DATA_WIDTH,
  parameter int CNT_WIDTH  = DIV_CNT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  iterative_divider_if.slave  bus
);

  localparam logic [DATA_WIDTH-1:0] C_ONE      = DATA_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  C_LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

  div_state_t            state_q,   state_d;
  logic [CNT_WIDTH-1:0]  cnt_q,     cnt_d;
  logic [DATA_WIDTH-1:0] rem_q,     rem_d;
  logic [DATA_WIDTH-1:0] quo_q,     quo_d;
  logic [DATA_WIDTH-1:0] div_q,     div_d;
  logic                  quo_neg_q, quo_neg_d;
  logic                  rem_neg_q, rem_neg_d;
  logic [DATA_WIDTH-1:0] lo_q,      lo_d;
  logic [DATA_WIDTH-1:0] hi_q,      hi_d;
  logic                  dbz_q,     dbz_d;
  logic                  done_q,    done_d;
  logic                  busy_q,    busy_d;

  logic [DATA_WIDTH-1:0] w_step_rem;
  logic [DATA_WIDTH-1:0] w_step_quo;
  logic                  w_op1_neg;
  logic                  w_op2_neg;
  logic [DATA_WIDTH-1:0] w_op1_mag;
  logic [DATA_WIDTH-1:0] w_op2_mag;

  // Two's complement negation modulo 2^DATA_WIDTH
  function automatic logic [DATA_WIDTH-1:0] negate(input logic [DATA_WIDTH-1:0] v);
    return ~v + C_ONE;
  endfunction

  iterative_divider_div_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_div_step (
    .i_rem     (rem_q),
    .i_quo     (quo_q),
    .i_divisor (div_q),
    .o_rem     (w_step_rem),
    .o_quo     (w_step_quo)
  );

  // Operand signs and magnitudes; abs(most-negative) stays 2^(W-1) unsigned
  always_comb begin
    w_op1_neg = bus.signed_div & bus.operand_1[DATA_WIDTH-1];
    w_op2_neg = bus.signed_div & bus.operand_2[DATA_WIDTH-1];
    w_op1_mag = w_op1_neg ? negate(bus.operand_1) : bus.operand_1;
    w_op2_mag = w_op2_neg ? negate(bus.operand_2) : bus.operand_2;
  end

  // Next-state: accept, iterate, fix up signs or report divide-by-zero
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.cancel) begin
          cnt_d     = '0;
          rem_d     = '0;
          div_d     = w_op2_mag;
          quo_neg_d = w_op1_neg ^ w_op2_neg;
          rem_neg_d = w_op1_neg;
          if (bus.operand_2 == '0) begin
            // The quotient register carries the raw dividend to ZERO,
            // where it is published unmodified as the remainder.
            quo_d   = bus.operand_1;
            state_d = ZERO;
          end else begin
            quo_d   = w_op1_mag;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = w_step_rem;
        quo_d = w_step_quo;
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (cnt_q == C_LAST_CNT) begin
          state_d = FIX;
        end
      end
      FIX: begin
        lo_d    = quo_neg_q ? negate(quo_q) : quo_q;
        hi_d    = rem_neg_q ? negate(rem_q) : rem_q;
        dbz_d   = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      ZERO: begin
        lo_d    = '1;
        hi_d    = quo_q;
        dbz_d   = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A flush abandons the operation and leaves published results alone
    if (bus.cancel && (state_q != IDLE)) begin
      state_d = IDLE;
      lo_d    = lo_q;
      hi_d    = hi_q;
      dbz_d   = dbz_q;
      done_d  = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  // State and result registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      lo_q      <= '0;
      hi_q      <= '0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      dbz_q     <= dbz_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result_lo   = lo_q;
  assign bus.result_hi   = hi_q;
  assign bus.div_by_zero = dbz_q;

endmodule : iterative_divider
`default_nettype wire

// File: tb/tb_iterative_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_iterative_divider
// Purpose  : Self-checking bench for iterative_divider: arithmetic reference
//            model plus directed vectors with hand-computed results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iterative_divider;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dbz;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;

  iterative_divider_if #(.DATA_WIDTH(W)) bus ();

  iterative_divider #(
    .DATA_WIDTH (W),
    .CNT_WIDTH  (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Compare one value against its expectation
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference division straight from the arithmetic definition
  function automatic res_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    res_t   r;
    longint sa;
    longint sb;
    if (b == '0) begin
      r.lo  = '1;
      r.hi  = a;
      r.dbz = 1'b1;
    end else if (s) begin
      sa    = longint'($signed(a));
      sb    = longint'($signed(b));
      r.lo  = W'(sa / sb);
      r.hi  = W'(sa % sb);
      r.dbz = 1'b0;
    end else begin
      r.lo  = a / b;
      r.hi  = a % b;
      r.dbz = 1'b0;
    end
    return r;
  endfunction

  // Cycle-level model: latency countdown, held results, cancel/reset rules
  int   m_left = 0;
  logic m_done = 1'b0;
  res_t m_out  = '0;
  res_t m_pend = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_out  <= '0;
      m_pend <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left != 0) begin
        if (bus.cancel) begin
          m_left <= 0;
        end else begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_done <= 1'b1;
            m_out  <= m_pend;
          end
        end
      end else if (bus.start && !bus.cancel) begin
        m_pend <= ref_div(bus.operand_1, bus.operand_2, bus.signed_div);
        m_left <= (bus.operand_2 == '0) ? 1 : W + 1;
      end
    end
  end

  // Every cycle, away from the active edge, the DUT must match the model
  always @(negedge clk) begin
    chk("cyc_busy", 64'(bus.busy), 64'(m_left != 0));
    chk("cyc_done", 64'(bus.done), 64'(m_done));
    chk("cyc_lo",   64'(bus.result_lo), 64'(m_out.lo));
    chk("cyc_hi",   64'(bus.result_hi), 64'(m_out.hi));
    chk("cyc_dbz",  64'(bus.div_by_zero), 64'(m_out.dbz));
  end

  // Issue one operation and check it against hand-computed values
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [W-1:0] elo, input logic [W-1:0] ehi, input logic edbz,
                        input int elat, input bit b2b, input bit noise);
    int n;
    if (!b2b) @(negedge clk);
    bus.operand_1  = a;
    bus.operand_2  = b;
    bus.signed_div = s;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_after_start", 64'(bus.busy), 64'd1);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (noise) begin
        bus.start      = (n == 4);
        bus.operand_1  = (n == 4) ? 32'h0000_DEAD : a;
        bus.operand_2  = (n == 4) ? 32'h0000_0000 : b;
        bus.signed_div = (n == 4) ? ~s : s;
      end
    end while (!bus.done && n < 200);
    bus.start = 1'b0;
    if (!bus.done) begin
      chk("done_timeout", 64'd0, 64'd1);
    end else begin
      chk("latency", 64'(n), 64'(elat));
      chk("lo",  64'(bus.result_lo), 64'(elo));
      chk("hi",  64'(bus.result_hi), 64'(ehi));
      chk("dbz", 64'(bus.div_by_zero), 64'(edbz));
      chk("busy_at_done", 64'(bus.busy), 64'd0);
    end
  endtask

  initial begin
    int pulses;
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.cancel     = 1'b0;
    bus.operand_1  = '0;
    bus.operand_2  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_lo",   64'(bus.result_lo), 64'd0);
    chk("rst_hi",   64'(bus.result_hi), 64'd0);
    chk("rst_dbz",  64'(bus.div_by_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic unsigned, signed sign combinations, overflow and wide unsigned
    run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33, 1'b0, 1'b0);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33, 1'b0, 1'b0);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 33, 1'b0, 1'b0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 33, 1'b0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 33, 1'b0, 1'b0);

    // Divide by zero
    run_op(32'd1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1, 1'b0, 1'b0);

    // Cancel part-way through: no done, previous results held
    @(negedge clk);
    bus.operand_1  = 32'd100;
    bus.operand_2  = 32'd7;
    bus.signed_div = 1'b0;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    bus.cancel = 1'b1;
    @(posedge clk); #1;
    bus.cancel = 1'b0;
    chk("cancel_busy", 64'(bus.busy), 64'd0);
    chk("cancel_done", 64'(bus.done), 64'd0);
    chk("cancel_lo",   64'(bus.result_lo), 64'hFFFF_FFFF);
    chk("cancel_hi",   64'(bus.result_hi), 64'd1234);
    chk("cancel_dbz",  64'(bus.div_by_zero), 64'd1);
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) pulses++;
    end
    chk("cancel_no_done", 64'(pulses), 64'd0);

    // Start ignored while busy, operands not resampled
    run_op(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 33, 1'b0, 1'b1);

    // Cancel in the done cycle leaves published results alone
    bus.cancel = 1'b1;
    @(posedge clk); #1;
    bus.cancel = 1'b0;
    chk("cancel_at_done_lo", 64'(bus.result_lo), 64'd3);
    chk("cancel_at_done_hi", 64'(bus.result_hi), 64'd0);

    // Cancel together with start in IDLE: start ignored
    @(negedge clk);
    bus.operand_1 = 32'd50;
    bus.operand_2 = 32'd5;
    bus.start     = 1'b1;
    bus.cancel    = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    chk("cancel_start_idle_busy", 64'(bus.busy), 64'd0);

    // Asynchronous reset mid-operation clears outputs at once
    @(negedge clk);
    bus.operand_1 = 32'd100;
    bus.operand_2 = 32'd7;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_done", 64'(bus.done), 64'd0);
    chk("arst_lo",   64'(bus.result_lo), 64'd0);
    chk("arst_hi",   64'(bus.result_hi), 64'd0);
    chk("arst_dbz",  64'(bus.div_by_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back operations, next start issued in the done cycle
    run_op(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, 33, 1'b0, 1'b0);
    run_op(32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33, 1'b1, 1'b0);
    run_op(32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_iterative_divider
`default_nettype wire

// File: doc/iterative_divider.md
Name: iterative_divider

Overview:
Multi-cycle radix-2 restoring divider for the EX stage. It implements DIV (signed) and DIVU (unsigned): quotient goes to LO, remainder to HI. It sits beside the combinational adder/ALU. The pipeline controller stalls on busy and flushes via cancel on exceptions.

Parameters:
DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH.
CNT_WIDTH, 5, iteration counter width, equal to clog2(DATA_WIDTH).

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request; sampled only in IDLE.
signed_div  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
cancel  input  1  synchronous abort (pipeline flush).
operand_1  input  DATA_WIDTH  dividend; sampled with start.
operand_2  input  DATA_WIDTH  divisor; sampled with start.
busy  output  1  high whenever state != IDLE.
done  output  1  one-cycle pulse; results valid.
result_lo  output  DATA_WIDTH  quotient.
result_hi  output  DATA_WIDTH  remainder.
div_by_zero  output  1  divisor was zero for the last completed op; held with results.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0, busy=0, done=0, result_lo=0, result_hi=0, div_by_zero=0. Reset mid-operation discards the operation immediately; no done.
- States: IDLE, CALC, FIX, ZERO.
- IDLE and start=1 and cancel=0 at edge T0:
  - Latch the operand magnitudes. Magnitude is abs() if signed_div, else the raw value.
  - Latch the quotient sign (sign1^sign2) and the remainder sign (sign1), both only if signed_div.
  - counter=0. Next state is ZERO if operand_2==0, else CALC.
- CALC, one iteration per edge:
  - Shift {rem, quo} left by 1.
  - Compute trial = rem - divisor, using DATA_WIDTH+1 bit arithmetic.
  - If trial is non-negative: rem = trial, quo LSB = 1. Else quo LSB = 0.
  - counter++. On the edge where counter==DATA_WIDTH-1, go to FIX.
  - Edges T1..T32 are the iterations for the default width.
- FIX, edge T33:
  - result_lo = quo, negated if the quotient sign is set.
  - result_hi = rem, negated if the remainder sign is set.
  - div_by_zero=0, done=1 for exactly one cycle, state back to IDLE.
  - Total: done is high in the cycle following edge DATA_WIDTH+1 after the start edge. busy is high from T0 through T33.
- ZERO, edge T1: result_lo = all ones, result_hi = operand_1 (raw), div_by_zero=1, done=1, state back to IDLE.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: no special case. Result is lo=0x80000000 (wraps), hi=0.
- Negation is two's complement at DATA_WIDTH, modulo 2^DATA_WIDTH. abs(0x80000000) = 0x80000000, treated as unsigned 2^31.
- start while busy: ignored; operands are not resampled.
- cancel:
  - In any non-IDLE state, the next edge forces IDLE. done stays 0, and result_*/div_by_zero keep their previous values.
  - cancel together with start in IDLE: cancel wins and start is ignored.
  - cancel in the same cycle as done=1 has no effect on the already-published results.
- start may be asserted in the cycle done=1 (state is IDLE), giving back-to-back operations.
- Results hold stable between done pulses.

Decomposition:
- Shared define header (div_def): state encodings (IDLE/CALC/FIX/ZERO), DATA_WIDTH default, the all-ones div-by-zero quotient constant.
- Sub-module div_step, combinational: takes rem, quo, and divisor; returns the next rem and quo for one restoring iteration.
- The FSM, counter and sign fix-up stay in iterative_divider.

Test Plan:
1. DIVU 100 / 7: start at T0 -> busy 1 on T0..T33, done pulse after T33, lo=14, hi=2, div_by_zero=0.
2. DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV 7 / 0xFFFFFFFE (-2) -> lo=0xFFFFFFFD, hi=1.
3. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 0xFFFFFFFF / 1 -> lo=0xFFFFFFFF, hi=0.
4. DIVU 1234 / 0 -> done one cycle after T1, lo=0xFFFFFFFF, hi=1234, div_by_zero=1, busy only on T0..T1.
5. Start 100/7, then cancel at iteration 10 -> IDLE next edge, no done, outputs still hold the prior values. Immediately after, start 9/3 -> lo=3, hi=0 on schedule. Start pulses during busy are ignored.
6. Deassert rst_n mid-CALC, asynchronously -> busy/done/results are 0 instantly. Release reset and run back-to-back ops, with start in the done cycle -> second op completes DATA_WIDTH+1 edges later.
